// File: rtl/risc_pkg.sv
// Shared core/memory-path types: data-memory access size, LSU bridge states
// and helpers for access byte count and alignment.
package risc_pkg;

  typedef enum logic [1:0] {
    OP_DMEM_BYTE = 2'd0,
    OP_DMEM_HALF = 2'd1,
    OP_DMEM_WORD = 2'd2
  } op_dmem_size;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_enum;

  // The unused size encoding is handled as a word access.
  function automatic logic [2:0] dmem_byte_count(input op_dmem_size size);
    case (size)
      OP_DMEM_BYTE: dmem_byte_count = 3'd1;
      OP_DMEM_HALF: dmem_byte_count = 3'd2;
      default:      dmem_byte_count = 3'd4;
    endcase
  endfunction

  function automatic logic dmem_is_misaligned(input op_dmem_size size, input logic [1:0] addr_lo);
    case (size)
      OP_DMEM_BYTE: dmem_is_misaligned = 1'b0;
      OP_DMEM_HALF: dmem_is_misaligned = addr_lo[0];
      default:      dmem_is_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of an assembled little-endian load word.
// Byte and half loads extend from bit 7/15; word loads pass through.
module load_extend
  import risc_pkg::*;
(
  input  logic [31:0] i_lanes,
  input  op_dmem_size i_size,
  input  logic        i_zero_ex,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_lanes;
    case (i_size)
      OP_DMEM_BYTE: o_data = {{24{~i_zero_ex & i_lanes[7]}}, i_lanes[7:0]};
      OP_DMEM_HALF: o_data = {{16{~i_zero_ex & i_lanes[15]}}, i_lanes[15:0]};
      default:      o_data = i_lanes;
    endcase
  end

endmodule

// File: rtl/lsu_byte_bridge.sv
// Serializes one core load/store into byte accesses on an 8-bit req/ack port,
// stalling the core until the access completes.
module lsu_byte_bridge
  import risc_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic                  dmem_req,
  input  logic                  dmem_wr,
  input  op_dmem_size           dmem_size,
  input  logic                  dmem_zero_ex,
  input  logic [31:0]           dmem_addr,
  input  logic [31:0]           dmem_wr_data,
  output logic [31:0]           dmem_rd_data,
  output logic                  dmem_stall,
  output logic                  dmem_done,
  output logic                  dmem_misaligned,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_ack
);

  lsu_state_enum         r_state;
  lsu_state_enum         w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  op_dmem_size           r_size;
  logic                  r_wr;
  logic                  r_zero_ex;
  logic [1:0]            r_cnt;
  logic [31:0]           r_lanes;
  logic [31:0]           w_lanes_next;
  logic [31:0]           w_ext;
  logic [7:0]            w_byte;
  logic [2:0]            w_count;
  logic                  w_last;
  logic                  w_misaligned;
  logic                  w_start;
  logic                  w_addr_unused;

  // Core address bits above the memory port width are intentionally dropped.
  assign w_addr_unused = ^dmem_addr[31:ADDR_WIDTH];

  assign w_count      = dmem_byte_count(r_size);
  assign w_last       = ({1'b0, r_cnt} == (w_count - 3'd1));
  assign w_misaligned = dmem_is_misaligned(dmem_size, dmem_addr[1:0]);
  assign w_start      = (r_state == LSU_IDLE) && dmem_req && !w_misaligned;

  always_comb begin
    w_byte       = r_wdata[7:0];
    w_lanes_next = r_lanes;
    case (r_cnt)
      2'd0: begin w_byte = r_wdata[7:0];   w_lanes_next[7:0]   = mem_rd_data; end
      2'd1: begin w_byte = r_wdata[15:8];  w_lanes_next[15:8]  = mem_rd_data; end
      2'd2: begin w_byte = r_wdata[23:16]; w_lanes_next[23:16] = mem_rd_data; end
      default: begin w_byte = r_wdata[31:24]; w_lanes_next[31:24] = mem_rd_data; end
    endcase
  end

  load_extend u_load_extend (
    .i_lanes   (w_lanes_next),
    .i_size    (r_size),
    .i_zero_ex (r_zero_ex),
    .o_data    (w_ext)
  );

  // IDLE outputs are gated by res_n so a held request cannot stall the core during reset.
  always_comb begin
    w_next_state    = r_state;
    mem_req         = 1'b0;
    mem_wr          = 1'b0;
    mem_addr        = '0;
    mem_wr_data     = '0;
    dmem_stall      = 1'b0;
    dmem_done       = 1'b0;
    dmem_misaligned = 1'b0;
    case (r_state)
      LSU_IDLE: begin
        if (dmem_req && res_n) begin
          if (w_misaligned) begin
            dmem_misaligned = 1'b1;
          end else begin
            dmem_stall   = 1'b1;
            w_next_state = LSU_BUSY;
          end
        end else begin
          w_next_state = LSU_IDLE;
        end
      end
      LSU_BUSY: begin
        mem_req     = 1'b1;
        mem_wr      = r_wr;
        mem_addr    = r_addr + ADDR_WIDTH'(r_cnt);
        mem_wr_data = w_byte;
        dmem_stall  = 1'b1;
        if (mem_ack && w_last) begin
          w_next_state = LSU_DONE;
        end else begin
          w_next_state = LSU_BUSY;
        end
      end
      LSU_DONE: begin
        dmem_done    = 1'b1;
        w_next_state = LSU_IDLE;
      end
      default: w_next_state = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state <= LSU_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_addr       <= '0;
      r_wdata      <= 32'd0;
      r_size       <= OP_DMEM_BYTE;
      r_wr         <= 1'b0;
      r_zero_ex    <= 1'b0;
      r_cnt        <= 2'd0;
      r_lanes      <= 32'd0;
      dmem_rd_data <= 32'd0;
    end else if (w_start) begin
      r_addr    <= dmem_addr[ADDR_WIDTH-1:0];
      r_wdata   <= dmem_wr_data;
      r_size    <= dmem_size;
      r_wr      <= dmem_wr;
      r_zero_ex <= dmem_zero_ex;
      r_cnt     <= 2'd0;
      r_lanes   <= 32'd0;
    end else if ((r_state == LSU_BUSY) && mem_ack) begin
      r_lanes <= w_lanes_next;
      if (w_last) begin
        if (!r_wr) begin
          dmem_rd_data <= w_ext;
        end
      end else begin
        r_cnt <= r_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_lsu_byte_bridge.sv
// Self-checking bench: directed scenarios plus randomized accesses against a
// byte-array memory and arithmetic load/store reference.
module tb_lsu_byte_bridge;
  import risc_pkg::*;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          res_n = 1'b0;
  logic          dmem_req = 1'b0;
  logic          dmem_wr = 1'b0;
  op_dmem_size   dmem_size = OP_DMEM_BYTE;
  logic          dmem_zero_ex = 1'b0;
  logic [31:0]   dmem_addr = 32'd0;
  logic [31:0]   dmem_wr_data = 32'd0;
  logic [31:0]   dmem_rd_data;
  logic          dmem_stall, dmem_done, dmem_misaligned;
  logic          mem_req, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wr_data;
  logic [7:0]    mem_rd_data = 8'd0;
  logic          mem_ack = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [7:0]    mem_model [0:65535];
  logic [AW-1:0] wlog_addr [$];
  logic [7:0]    wlog_data [$];
  logic [31:0]   exp_rd = 32'd0;

  always #5 clk = ~clk;

  lsu_byte_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(8)) dut (
    .clk(clk), .res_n(res_n), .dmem_req(dmem_req), .dmem_wr(dmem_wr),
    .dmem_size(dmem_size), .dmem_zero_ex(dmem_zero_ex), .dmem_addr(dmem_addr),
    .dmem_wr_data(dmem_wr_data), .dmem_rd_data(dmem_rd_data), .dmem_stall(dmem_stall),
    .dmem_done(dmem_done), .dmem_misaligned(dmem_misaligned), .mem_req(mem_req),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .mem_ack(mem_ack)
  );

  function automatic int nbytes(input op_dmem_size s);
    return (s == OP_DMEM_BYTE) ? 1 : (s == OP_DMEM_HALF) ? 2 : 4;
  endfunction

  function automatic logic ref_misaligned(input op_dmem_size s, input logic [31:0] a);
    return (s == OP_DMEM_HALF && a[0]) || (s == OP_DMEM_WORD && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input op_dmem_size s, input logic zx);
    longint v = 0;
    int n = nbytes(s);
    for (int k = 0; k < n; k++) v += longint'(mem_model[(a + k) % 65536]) << (8 * k);
    if (!zx && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  // Presents one request, acks every period-th BUSY cycle, commits writes to the model.
  task automatic do_access(input logic wr, input op_dmem_size size, input logic zx,
                           input logic [31:0] addr, input logic [31:0] wdata, input int period,
                           input logic scramble, output int stall_cnt, output int done_cyc,
                           output logic mis_seen, output logic req_seen, output logic hold_ok);
    int wait_cnt = 0;
    logic prev_wait = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    stall_cnt = 0; done_cyc = 0; mis_seen = 1'b0; req_seen = 1'b0; hold_ok = 1'b1;
    wlog_addr.delete(); wlog_data.delete();
    dmem_req = 1'b1; dmem_wr = wr; dmem_size = size; dmem_zero_ex = zx;
    dmem_addr = addr; dmem_wr_data = wdata;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (dmem_stall) stall_cnt++;
      if (dmem_misaligned) mis_seen = 1'b1;
      if (dmem_done) done_cyc = cyc;
      if (mem_req) begin
        req_seen = 1'b1;
        if (prev_wait && mem_addr !== prev_addr) hold_ok = 1'b0;
        mem_rd_data = mem_model[mem_addr];
        mem_ack = (wait_cnt == period - 1);
        wait_cnt = mem_ack ? 0 : wait_cnt + 1;
        prev_wait = !mem_ack;
        prev_addr = mem_addr;
        if (mem_ack && mem_wr) begin
          mem_model[mem_addr] = mem_wr_data;
          wlog_addr.push_back(mem_addr);
          wlog_data.push_back(mem_wr_data);
        end
      end else begin
        mem_ack = scramble ? 1'($urandom_range(1)) : 1'b0;
        mem_rd_data = 8'($urandom);
      end
      @(posedge clk); #1;
      if (done_cyc != 0 || mis_seen) break;
      if (scramble) begin
        dmem_req = 1'($urandom_range(1)); dmem_wr = 1'($urandom_range(1));
        dmem_size = op_dmem_size'($urandom_range(2)); dmem_zero_ex = 1'($urandom_range(1));
        dmem_addr = $urandom; dmem_wr_data = $urandom;
      end
    end
    dmem_req = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    res_n = 1'b0;
    dmem_req = 1'b1; dmem_size = OP_DMEM_WORD; dmem_addr = 32'h100;
    #12;
    checks++;
    if ({mem_req, mem_wr, dmem_stall, dmem_done, dmem_misaligned} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b required 00000", {mem_req, mem_wr, dmem_stall, dmem_done, dmem_misaligned});
    end
    checks++;
    if (mem_addr !== 16'h0 || mem_wr_data !== 8'h0) begin
      failures++; $display("FAIL reset_mem_bus: addr %h data %h required 0", mem_addr, mem_wr_data);
    end
    checks++;
    if (dmem_rd_data !== 32'h0) begin
      failures++; $display("FAIL reset_rd_data: got %h required 0", dmem_rd_data);
    end
    dmem_req = 1'b0;
    @(negedge clk); res_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_word();
    int st, dc; logic ms, rs, ho;
    logic [AW-1:0] ea [4] = '{16'h100, 16'h101, 16'h102, 16'h103};
    logic [7:0] ed [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_access(1'b1, OP_DMEM_WORD, 1'b0, 32'h100, 32'hDEADBEEF, 1, 1'b0, st, dc, ms, rs, ho);
    checks++;
    if (st !== 5 || dc !== 6) begin
      failures++; $display("FAIL sw_timing: stall %0d done %0d required 5 6", st, dc);
    end
    checks++;
    if (wlog_addr.size() != 4) begin
      failures++; $display("FAIL sw_count: got %0d writes required 4", wlog_addr.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (wlog_addr[k] !== ea[k] || wlog_data[k] !== ed[k]) begin
          failures++;
          $display("FAIL sw_byte%0d: got %h@%h required %h@%h", k, wlog_data[k], wlog_addr[k], ed[k], ea[k]);
        end
      end
    end
    checks++;
    if (dmem_rd_data !== exp_rd) begin
      failures++; $display("FAIL sw_rd_hold: got %h required %h", dmem_rd_data, exp_rd);
    end
  endtask

  task automatic test_load_byte();
    int st, dc; logic ms, rs, ho;
    mem_model[16'h20] = 8'h80;
    do_access(1'b0, OP_DMEM_BYTE, 1'b0, 32'h20, 32'h0, 1, 1'b0, st, dc, ms, rs, ho);
    exp_rd = 32'hFFFFFF80;
    checks++;
    if (dmem_rd_data !== 32'hFFFFFF80 || st !== 2) begin
      failures++; $display("FAIL lb: got %h stall %0d required ffffff80 stall 2", dmem_rd_data, st);
    end
    do_access(1'b0, OP_DMEM_BYTE, 1'b1, 32'h20, 32'h0, 1, 1'b0, st, dc, ms, rs, ho);
    exp_rd = 32'h00000080;
    checks++;
    if (dmem_rd_data !== 32'h00000080 || st !== 2) begin
      failures++; $display("FAIL lbu: got %h stall %0d required 00000080 stall 2", dmem_rd_data, st);
    end
  endtask

  task automatic test_load_half_wait();
    int st, dc; logic ms, rs, ho;
    mem_model[16'h40] = 8'h12; mem_model[16'h41] = 8'h34;
    do_access(1'b0, OP_DMEM_HALF, 1'b0, 32'h40, 32'h0, 3, 1'b0, st, dc, ms, rs, ho);
    exp_rd = 32'h00003412;
    checks++;
    if (dmem_rd_data !== 32'h00003412 || st !== 7 || dc !== 8) begin
      failures++; $display("FAIL lh_wait: got %h stall %0d done %0d required 00003412 7 8", dmem_rd_data, st, dc);
    end
    checks++;
    if (!ho) begin
      failures++; $display("FAIL lh_addr_hold: got moved required held");
    end
  endtask

  task automatic test_misaligned();
    int st, dc; logic ms, rs, ho;
    do_access(1'b0, OP_DMEM_WORD, 1'b0, 32'h102, 32'h0, 1, 1'b0, st, dc, ms, rs, ho);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ms !== 1'b1 || rs !== 1'b0 || st !== 0 || dc !== 0) begin
      failures++; $display("FAIL lw_misaligned: mis %b req %b stall %0d done %0d required 1 0 0 0", ms, rs, st, dc);
    end
    checks++;
    if (dmem_rd_data !== exp_rd || mem_req !== 1'b0) begin
      failures++; $display("FAIL misaligned_hold: rd %h req %b required %h 0", dmem_rd_data, mem_req, exp_rd);
    end
  endtask

  task automatic test_addr_wrap();
    int st, dc; logic ms, rs, ho;
    do_access(1'b1, OP_DMEM_WORD, 1'b0, 32'h0001FFFC, 32'hA1B2C3D4, 1, 1'b0, st, dc, ms, rs, ho);
    checks++;
    if (wlog_addr.size() != 4 || wlog_addr[0] !== 16'hFFFC || wlog_addr[3] !== 16'hFFFF || wlog_data[3] !== 8'hA1) begin
      failures++; $display("FAIL addr_wrap: %0d writes, first %h last %h required 4 fffc ffff", wlog_addr.size(),
                           (wlog_addr.size() > 0) ? wlog_addr[0] : 16'h0, (wlog_addr.size() > 3) ? wlog_addr[3] : 16'h0);
    end
  endtask

  task automatic test_reset_mid();
    int st, dc; logic ms, rs, ho;
    for (int k = 0; k < 4; k++) mem_model[16'h200 + k] = 8'hAA;
    dmem_req = 1'b1; dmem_wr = 1'b1; dmem_size = OP_DMEM_WORD; dmem_addr = 32'h200;
    dmem_wr_data = 32'h11223344; mem_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_req && mem_wr && mem_ack) mem_model[mem_addr] = mem_wr_data;
      @(posedge clk);
    end
    #2 res_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || dmem_stall !== 1'b0 || dmem_done !== 1'b0) begin
      failures++; $display("FAIL reset_mid: req %b stall %b done %b required 0 0 0", mem_req, dmem_stall, dmem_done);
    end
    dmem_req = 1'b0; mem_ack = 1'b0; exp_rd = 32'h0;
    @(negedge clk); res_n = 1'b1;
    @(posedge clk); #1;
    do_access(1'b0, OP_DMEM_WORD, 1'b0, 32'h200, 32'h0, 1, 1'b0, st, dc, ms, rs, ho);
    exp_rd = 32'hAAAA3344;
    checks++;
    if (dmem_rd_data !== 32'hAAAA3344 || st !== 5) begin
      failures++; $display("FAIL reset_recover: got %h stall %0d required aaaa3344 stall 5", dmem_rd_data, st);
    end
  endtask

  task automatic test_random();
    int st, dc, n, per; logic ms, rs, ho, wr, zx, mis;
    op_dmem_size sz; logic [31:0] a, wd, exp;
    for (int it = 0; it < 40; it++) begin
      wr = 1'($urandom_range(1)); zx = 1'($urandom_range(1));
      sz = op_dmem_size'($urandom_range(2)); n = nbytes(sz);
      a = $urandom; wd = $urandom; per = $urandom_range(1, 3);
      if ($urandom_range(3) != 0) a = a & ~(32'(n) - 32'd1);
      mis = ref_misaligned(sz, a);
      exp = ref_load(a, sz, zx);
      do_access(wr, sz, zx, a, wd, per, 1'b1, st, dc, ms, rs, ho);
      if (mis) begin
        checks++;
        if (!ms || rs || st != 0 || dmem_rd_data !== exp_rd) begin
          failures++; $display("FAIL rnd_mis[%0d]: mis %b req %b stall %0d rd %h required 1 0 0 %h", it, ms, rs, st, dmem_rd_data, exp_rd);
        end
        continue;
      end
      checks++;
      if (ms || st != 1 + n * per || dc != st + 1 || !ho) begin
        failures++; $display("FAIL rnd_timing[%0d]: mis %b stall %0d done %0d hold %b required 0 %0d %0d 1", it, ms, st, dc, ho, 1 + n * per, 2 + n * per);
      end
      if (!wr) exp_rd = exp;
      checks++;
      if (dmem_rd_data !== exp_rd) begin
        failures++; $display("FAIL rnd_rd[%0d]: got %h required %h", it, dmem_rd_data, exp_rd);
      end
      checks++;
      if (wlog_addr.size() != (wr ? n : 0)) begin
        failures++; $display("FAIL rnd_wcount[%0d]: got %0d required %0d", it, wlog_addr.size(), wr ? n : 0);
      end else begin
        for (int k = 0; k < wlog_addr.size(); k++) begin
          if (wlog_addr[k] !== AW'(a + k) || wlog_data[k] !== wd[8*k +: 8]) begin
            failures++; $display("FAIL rnd_wbyte[%0d/%0d]: got %h@%h required %h@%h", it, k, wlog_data[k], wlog_addr[k], wd[8*k +: 8], AW'(a + k));
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem_model[i] = 8'($urandom);
    test_reset();
    test_store_word();
    test_load_byte();
    test_load_half_wait();
    test_misaligned();
    test_addr_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_byte_bridge.md
Name: lsu_byte_bridge

Overview:
Load/store bridge that sits directly downstream of the single-cycle core's data-memory request signals.
- Takes one core load/store (byte/half/word) and serializes it into byte accesses on an 8-bit req/ack memory port.
- Stalls the core while an access is in flight.
- Returns sign- or zero-extended load data.
- Replaces the core's zero-latency data memory connection when the backing memory has wait states.

Parameters:
ADDR_WIDTH, 16, byte-address width of memory port; upper core address bits are discarded
DATA_WIDTH, 8, memory port data width; only 8 is supported

Ports:
clk  in  1  clock, rising edge
res_n  in  1  asynchronous active-low reset
dmem_req  in  1  core requests a data access this instruction
dmem_wr  in  1  1 = store, 0 = load
dmem_size  in  op_dmem_size  access size: OP_DMEM_BYTE / OP_DMEM_HALF / OP_DMEM_WORD
dmem_zero_ex  in  1  1 = zero-extend load, 0 = sign-extend
dmem_addr  in  32  core byte address
dmem_wr_data  in  32  store data; low bytes used for byte/half
dmem_rd_data  out  32  extended load result, registered
dmem_stall  out  1  core must hold pc and instruction while high
dmem_done  out  1  one-cycle pulse when access completes
dmem_misaligned  out  1  one-cycle pulse on misaligned request
mem_req  out  1  byte access request
mem_wr  out  1  byte write enable
mem_addr  out  ADDR_WIDTH  byte address
mem_wr_data  out  8  write byte
mem_rd_data  in  8  read byte, valid with mem_ack
mem_ack  in  1  byte access accepted/complete this cycle

Behaviour:
- Reset (async, immediate):
  - State IDLE.
  - Outputs forced low: mem_req, mem_wr, dmem_stall, dmem_done, dmem_misaligned.
  - mem_addr = 0, mem_wr_data = 0, dmem_rd_data = 0.
  - Reset mid-transaction abandons it; bytes already written stay written.
- Byte count N: 1 for byte, 2 for half, 4 for word. Little-endian: byte k maps to address base+k, data bits [8k+7:8k].
- Misaligned request: half with addr[0]=1, or word with addr[1:0]!=0.
  - In IDLE this pulses dmem_misaligned for the cycle.
  - No stall, no memory access, dmem_rd_data unchanged.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: on a valid aligned dmem_req, dmem_stall=1 combinationally.
  - IDLE: at the clock edge, latch addr, wr_data, size, wr and zero_ex; set byte count=0; go to BUSY.
  - BUSY: mem_req=1 and mem_wr=latched wr.
  - BUSY: mem_addr = (latched addr + count) mod 2^ADDR_WIDTH; mem_wr_data = latched byte[count]; dmem_stall=1.
  - BUSY: on mem_ack, for loads capture mem_rd_data into lane[count]. If count==N-1 go to DONE, else count++.
  - BUSY: mem_req stays high across consecutive bytes. Address and data update on the cycle after each ack.
  - DONE: dmem_stall=0 and dmem_done=1; the core advances at this edge. Loads present the final dmem_rd_data here. Next state is IDLE unconditionally.
  - DONE: a request seen during DONE belongs to the completing instruction and is ignored.
- Load extension: byte/half are extended from bit 7/15 per dmem_zero_ex; word is passed through.
- dmem_rd_data updates only at load completion and holds otherwise.
- Latency with mem_ack high every BUSY cycle: dmem_stall is high for N+1 cycles and the instruction occupies N+2 cycles. Each extra wait cycle adds one.
- Zero-wait memory: ack in the same cycle mem_req first rises is legal.
- Inputs change or dmem_req drops during BUSY: ignored; the latched transaction completes.
- mem_ack while mem_req=0: ignored.

Decomposition:
- risc_pkg: op_dmem_size, already shared.
- risc_pkg additions:
  - new enum lsu_state_enum {LSU_IDLE, LSU_BUSY, LSU_DONE};
  - helper constant function for byte count per size.
- One natural sub-module: load_extend. It is combinational: assembled 32-bit lanes + size + zero_ex in, extended word out, and is reusable by other memory paths.

Test Plan:
- Store word 0xDEADBEEF at 0x100, ack every cycle -> mem_wr bytes EF,BE,AD,DE at 0x100..0x103 on consecutive cycles; stall high 5 cycles; dmem_done pulses on cycle 6.
- Byte 0x80 at 0x20: LB -> dmem_rd_data 0xFFFFFF80; LBU -> 0x00000080. Stall high 2 cycles each.
- LH from 0x40 holding {0x12,0x34}, ack only every 3rd cycle -> 0x00003412; stall high 7 cycles; mem_addr held during waits.
- LW at 0x102 -> dmem_misaligned pulse, mem_req never rises, no stall, dmem_rd_data unchanged.
- Word store to 0x0001FFFC with ADDR_WIDTH=16 -> mem_addr 0xFFFC..0xFFFF.
- Reset asserted after 2 acked bytes of a word store -> mem_req and dmem_stall drop immediately; after release the FSM is IDLE and the next load completes normally.
